// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// burst default and the saturating burst-counter helper.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam int BURST_MAX_DEFAULT = 4;
  localparam int BURST_W           = 4;
  localparam int DIGIT_W           = 3;
  localparam int NUM_PORTS         = 2;

  // Counter stops at the limit so a long contested hold cannot wrap past it.
  function automatic logic [BURST_W-1:0] burst_sat_inc(
    input logic [BURST_W-1:0] cnt,
    input logic [BURST_W-1:0] limit
  );
    burst_sat_inc = (cnt < limit) ? cnt + 1'b1 : cnt;
  endfunction

endpackage

// File: rtl/dm_arbiter.sv
// Two-port round-robin data-memory arbiter with bounded bursts under contention.
// Grants are registered; the memory-side mux follows the owning port combinationally.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int AW        = 9,
  parameter int DW        = 32,
  parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [AW-1:0]      addr0,
  input  logic [AW-1:0]      addr1,
  input  logic [DW-1:0]      wdata0,
  input  logic [DW-1:0]      wdata1,
  input  logic [DIGIT_W-1:0] digit0,
  input  logic [DIGIT_W-1:0] digit1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [DW-1:0]      rdata0,
  output logic [DW-1:0]      rdata1,
  output logic               dm_we,
  output logic [AW-1:0]      dm_addr,
  output logic [DW-1:0]      dm_din,
  output logic [DIGIT_W-1:0] dm_digit,
  input  logic [DW-1:0]      dm_dout
);

  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(BURST_MAX);

  state_t               state_reg, state_next;
  logic                 last_owner_reg, last_owner_next;
  logic [BURST_W-1:0]   burst_cnt_reg, burst_cnt_next;

  logic [NUM_PORTS-1:0] req_vec;
  logic [NUM_PORTS-1:0] own_vec;
  logic [NUM_PORTS-1:0] we_vec;
  logic [NUM_PORTS-1:0] xfer_vec;

  assign req_vec = {req1, req0};
  assign we_vec  = {we1, we0};
  assign own_vec = {state_reg == ST_OWN1, state_reg == ST_OWN0};

  // A transfer needs both the registered grant and a still-live request.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_xfer
      assign xfer_vec[gi] = req_vec[gi] & own_vec[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      last_owner_reg <= 1'b1;
      burst_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      burst_cnt_reg  <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    burst_cnt_next  = burst_cnt_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_next = last_owner_reg ? ST_OWN0 : ST_OWN1;
        end else if (req0) begin
          state_next = ST_OWN0;
        end else if (req1) begin
          state_next = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!req0) begin
          state_next = req1 ? ST_OWN1 : ST_IDLE;
        end else if (req1 && (burst_cnt_reg >= BURST_LIMIT)) begin
          state_next = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          state_next = req0 ? ST_OWN0 : ST_IDLE;
        end else if (req0 && (burst_cnt_reg >= BURST_LIMIT)) begin
          state_next = ST_OWN0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Burst length restarts on every ownership entry, counts while held.
    if (state_next == ST_OWN0 && state_reg != ST_OWN0) begin
      last_owner_next = 1'b0;
      burst_cnt_next  = BURST_W'(1);
    end else if (state_next == ST_OWN1 && state_reg != ST_OWN1) begin
      last_owner_next = 1'b1;
      burst_cnt_next  = BURST_W'(1);
    end else if (state_next != ST_IDLE) begin
      burst_cnt_next  = burst_sat_inc(burst_cnt_reg, BURST_LIMIT);
    end else begin
      burst_cnt_next  = '0;
    end
  end

  assign gnt0 = own_vec[0];
  assign gnt1 = own_vec[1];

  always_comb begin
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_din   = '0;
    dm_digit = '0;
    if (own_vec[0]) begin
      dm_we    = we_vec[0] & xfer_vec[0];
      dm_addr  = addr0;
      dm_din   = wdata0;
      dm_digit = digit0;
    end else if (own_vec[1]) begin
      dm_we    = we_vec[1] & xfer_vec[1];
      dm_addr  = addr1;
      dm_din   = wdata1;
      dm_digit = digit1;
    end
  end

  assign rdata0 = dm_dout;
  assign rdata1 = dm_dout;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: behavioural memory, default-burst instance
// plus a BURST_MAX=1 instance for per-cycle alternation.
module tb_dm_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [2:0]    digit0, digit1;
  logic          gnt0, gnt1, dm_we;
  logic [DW-1:0] rdata0, rdata1, dm_din, dm_dout;
  logic [AW-1:0] dm_addr;
  logic [2:0]    dm_digit;

  logic          b_req0, b_req1;
  logic          b_gnt0, b_gnt1, b_dm_we;
  logic [DW-1:0] b_rdata0, b_rdata1, b_dm_din;
  logic [DW-1:0] b_dout;
  logic [AW-1:0] b_dm_addr;
  logic [2:0]    b_dm_digit;

  logic [DW-1:0] tb_mem [0:(1<<AW)-1];
  int            wr_count = 0;
  int            tests_run = 0;
  int            tests_failed = 0;
  int            snap;

  always #5 clk = ~clk;

  assign dm_dout = tb_mem[dm_addr];
  assign b_dout  = '0;

  always @(posedge clk) begin
    if (dm_we) begin
      tb_mem[dm_addr] <= dm_din;
      wr_count        <= wr_count + 1;
    end
  end

  dm_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .digit0(digit0), .digit1(digit1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_digit(dm_digit),
    .dm_dout(dm_dout)
  );

  dm_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(1)) u_dut_b1 (
    .clk(clk), .reset(reset),
    .req0(b_req0), .req1(b_req1), .we0(1'b0), .we1(1'b0),
    .addr0(9'h001), .addr1(9'h002), .wdata0(32'h0), .wdata1(32'h0),
    .digit0(3'd0), .digit1(3'd0),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_din(b_dm_din), .dm_digit(b_dm_digit),
    .dm_dout(b_dout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked 1ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; digit0 = '0; digit1 = '0;
    b_req0 = 0; b_req1 = 0;
    cyc(); cyc();

    // Reset state
    reset = 1'b0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_dm_addr", dm_addr, 0);

    // Single-port write then read-back
    req0 = 1; we0 = 1; addr0 = 9'h010; wdata0 = 32'hDEADBEEF; digit0 = 3'd5;
    #1;
    chk("s1_gnt0_latency", gnt0, 0);
    cyc(); #1;
    chk("s1_gnt0", gnt0, 1);
    chk("s1_dm_we", dm_we, 1);
    chk("s1_dm_addr", dm_addr, 9'h010);
    chk("s1_dm_din", dm_din, 32'hDEADBEEF);
    chk("s1_dm_digit", dm_digit, 3'd5);
    cyc();
    we0 = 0;
    #1;
    chk("s1_rdata0", rdata0, 32'hDEADBEEF);
    chk("s1_read_no_we", dm_we, 0);
    req0 = 0;
    #1;
    chk("s1_stale_gnt_no_we", dm_we, 0);
    cyc(); #1;
    chk("s1_idle_gnt0", gnt0, 0);
    chk("s1_idle_addr", dm_addr, 0);
    $display("[TB] scenario single write/read done");

    // Tie right after reset, bursts of 4 alternating
    reset = 1; cyc(); reset = 0;
    req0 = 1; req1 = 1; addr0 = 9'h020; addr1 = 9'h030;
    #1;
    chk("s2_no_gnt_yet", {gnt1, gnt0}, 2'b00);
    for (int i = 0; i < 16; i++) begin
      cyc(); #1;
      chk($sformatf("s2_gnt_c%0d", i), {gnt1, gnt0}, ((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("s2_addr_c%0d", i), dm_addr, ((i / 4) % 2 == 0) ? 9'h020 : 9'h030);
    end
    req0 = 0; req1 = 0;
    cyc(); #1;
    chk("s2_idle", {gnt1, gnt0}, 2'b00);
    $display("[TB] scenario burst alternation done");

    // Uncontested port1 holds
    req1 = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      chk($sformatf("s3_hold_c%0d", i), {gnt1, gnt0}, 2'b10);
    end
    req1 = 0;
    cyc();
    $display("[TB] scenario uncontested hold done");

    // Owner drops request while other waits
    req0 = 1; we0 = 1; addr0 = 9'h040; wdata0 = 32'h11111111;
    req1 = 1; we1 = 0; addr1 = 9'h050;
    cyc(); #1;
    chk("s4_gnt0", {gnt1, gnt0}, 2'b01);
    snap = wr_count;
    req0 = 0;
    #1;
    chk("s4_drop_no_we", dm_we, 0);
    cyc(); #1;
    chk("s4_handover", {gnt1, gnt0}, 2'b10);
    chk("s4_read_no_we", dm_we, 0);
    chk("s4_addr1", dm_addr, 9'h050);
    chk("s4_no_write", wr_count, snap);
    req1 = 0; we0 = 0;
    cyc();
    $display("[TB] scenario request drop done");

    // Reset during port1 write burst
    req1 = 1; we1 = 1; addr1 = 9'h060; wdata1 = 32'hCAFEF00D;
    cyc(); #1;
    chk("s5_gnt1", gnt1, 1);
    chk("s5_dm_we", dm_we, 1);
    cyc();
    reset = 1;
    cyc(); #1;
    snap = wr_count;
    chk("s5_rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("s5_rst_we", dm_we, 0);
    wdata1 = 32'h12345678;
    cyc(); cyc(); #1;
    chk("s5_no_write_after_rst", wr_count, snap);
    reset = 0; req1 = 0; we1 = 0;
    req0 = 1; req1 = 1; we0 = 0; addr0 = 9'h060;
    cyc(); #1;
    chk("s5_tie_port0", {gnt1, gnt0}, 2'b01);
    chk("s5_readback", rdata0, 32'hCAFEF00D);
    req0 = 0; req1 = 0;
    cyc();
    $display("[TB] scenario reset mid-burst done");

    // BURST_MAX=1 alternates every cycle
    b_req0 = 1; b_req1 = 1;
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      chk($sformatf("s6_alt_c%0d", i), {b_gnt1, b_gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    b_req0 = 0; b_req1 = 0;
    cyc();
    $display("[TB] scenario single-cycle burst done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
